// File: rtl/bitrev_writer_pkg.sv
// fft_reorder_pkg: FSM state encoding and a width-generic bit-reversal helper.
// Rev 1.0
`default_nettype none

package fft_reorder_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_FILL  = S_FILL,
        ST_DRAIN = S_DRAIN
    } state_e;

    // Reverses the low 'size' bits of v; bits above 'size' come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned size);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(size)) r[int'(size) - 1 - i] = v[i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitrev_writer_if.sv
// bitrev_writer_if: sample-in / sample-out handshake bundle (out_last under BITREV_WRITER_LAST_EN).
// Rev 1.0
`default_nettype none

interface bitrev_writer_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
`ifdef BITREV_WRITER_LAST_EN
    logic          out_last;
`endif

    modport master (
        output in_valid, in_data, out_ready,
`ifdef BITREV_WRITER_LAST_EN
        input  out_last,
`endif
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef BITREV_WRITER_LAST_EN
        output out_last,
`endif
        output in_ready, out_valid, out_data
    );

endinterface

`default_nettype wire

// File: rtl/bitrev_writer_ram.sv
// reorder_ram: N x DW frame buffer, one write port and one registered, enabled read port.
// Rev 1.0
`default_nettype none

module reorder_ram #(
    parameter int N    = 16,
    parameter int SIZE = 4,
    parameter int DW   = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            we_i,
    input  wire logic [SIZE-1:0] waddr_i,
    input  wire logic [DW-1:0]   wdata_i,
    input  wire logic            re_i,
    input  wire logic [SIZE-1:0] raddr_i,
    output logic      [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [N];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Only the output register is cleared; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/bitrev_writer.sv
// bitrev_writer: buffers one frame written in bit-reversed order, drains it sequentially.
// Optional out_last via BITREV_WRITER_LAST_EN. Rev 1.0
`default_nettype none

module bitrev_writer
    import fft_reorder_pkg::*;
#(
    parameter int N    = 16,
    parameter int SIZE = 4,
    parameter int DW   = 32
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bitrev_writer_if.slave   bus,
    output logic             busy
);

    state_e            state_q, state_d;
    logic [SIZE-1:0]   wr_cnt_q, wr_cnt_d;
    logic [SIZE-1:0]   rd_cnt_q, rd_cnt_d;
    logic              rd_done_q, rd_done_d;
    logic              out_valid_q, out_valid_d;

    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_rd_en;
    logic [SIZE-1:0]   w_wr_addr;

    assign bus.in_ready = (state_q != ST_DRAIN);
    assign w_in_hs      = bus.in_valid && bus.in_ready;
    assign w_out_hs     = out_valid_q && bus.out_ready;
    // Fetch the next sample whenever the output register is empty or being consumed.
    assign w_rd_en      = (state_q == ST_DRAIN) && !rd_done_q && (!out_valid_q || bus.out_ready);
    assign w_wr_addr    = SIZE'(bitrev(32'(wr_cnt_q), SIZE));

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rd_done_d   = rd_done_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (w_in_hs) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    state_d  = (wr_cnt_q == SIZE'(N - 1)) ? ST_DRAIN : ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (w_rd_en) begin
                    rd_cnt_d    = rd_cnt_q + 1'b1;
                    rd_done_d   = (rd_cnt_q == SIZE'(N - 1));
                    out_valid_d = 1'b1;
                end else if (w_out_hs) begin
                    out_valid_d = 1'b0;
                    if (rd_done_q) begin
                        rd_done_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            rd_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_done_q   <= rd_done_d;
            out_valid_q <= out_valid_d;
        end
    end

    reorder_ram #(
        .N    (N),
        .SIZE (SIZE),
        .DW   (DW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_in_hs),
        .waddr_i (w_wr_addr),
        .wdata_i (bus.in_data),
        .re_i    (w_rd_en),
        .raddr_i (rd_cnt_q),
        .rdata_o (bus.out_data)
    );

    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != ST_IDLE);

`ifdef BITREV_WRITER_LAST_EN
    // The final address has been fetched exactly while index N-1 sits in the output register.
    assign bus.out_last = out_valid_q && rd_done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitrev_writer.sv
// tb_bitrev_writer: scoreboard bench for bitrev_writer with a frame-level reference model.
// Rev 1.0
`default_nettype none

module tb_bitrev_writer;

    localparam int N    = 16;
    localparam int SIZE = 4;
    localparam int DW   = 32;

    typedef struct {
        logic [DW-1:0] data;
        int            idx;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;

    bitrev_writer_if #(.DW(DW)) bus_if ();

    bitrev_writer #(.N(N), .SIZE(SIZE), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] frame_q[$];
    int            fill_cnt   = 0;
    int            drain_left = 0;
    int            out_cnt    = 0;
    int            lat_cnt    = 0;
    bit            rst_chk    = 0;
    bit            stall_q    = 0;
    logic [DW-1:0] stall_data = '0;
    int            rdy_mode   = 0;
    int            rdy_phase  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_bitrev(input int k);
        int r = 0;
        int v = k;
        for (int b = 0; b < SIZE; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    // Monitor / scoreboard: checks, then folds this cycle's handshakes into the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", {63'd0, bus_if.in_ready}, {63'd0, drain_left == 0});
            chk("busy", {63'd0, busy}, {63'd0, (fill_cnt > 0) || (drain_left > 0)});
            if (lat_cnt == 1) begin
                chk("latency_c1_valid", {63'd0, bus_if.out_valid}, 64'd0);
                lat_cnt = 2;
            end else if (lat_cnt == 2) begin
                chk("latency_c2_valid", {63'd0, bus_if.out_valid}, 64'd1);
                lat_cnt = 0;
            end
            if (rst_chk) begin
                chk("reset_out_data", {32'd0, bus_if.out_data}, 64'd0);
                chk("reset_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
                rst_chk = 0;
            end
            if (stall_q) begin
                chk("stall_valid", {63'd0, bus_if.out_valid}, 64'd1);
                chk("stall_data", {32'd0, bus_if.out_data}, {32'd0, stall_data});
            end
            if (bus_if.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got out_valid=1 required 0 at %0t", $time);
                end else begin
                    chk("out_data", {32'd0, bus_if.out_data}, {32'd0, exp_q[0].data});
`ifdef BITREV_WRITER_LAST_EN
                    chk("out_last", {63'd0, bus_if.out_last}, {63'd0, exp_q[0].idx == N - 1});
`endif
                end
            end
`ifdef BITREV_WRITER_LAST_EN
            else begin
                chk("out_last_idle", {63'd0, bus_if.out_last}, 64'd0);
            end
`endif
            stall_q    = bus_if.out_valid && !bus_if.out_ready;
            stall_data = bus_if.out_data;

            if (!rst_n) begin
                exp_q.delete();
                frame_q.delete();
                fill_cnt   = 0;
                drain_left = 0;
                out_cnt    = 0;
                lat_cnt    = 0;
                stall_q    = 0;
                rst_chk    = 1;
            end else begin
                if (bus_if.out_valid && bus_if.out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    drain_left--;
                    out_cnt++;
                end
                if (bus_if.in_valid && bus_if.in_ready) begin
                    frame_q.push_back(bus_if.in_data);
                    fill_cnt++;
                    if (fill_cnt == N) begin
                        for (int k = 0; k < N; k++) begin
                            exp_t e;
                            e.data = frame_q[ref_bitrev(k)];
                            e.idx  = k;
                            exp_q.push_back(e);
                        end
                        frame_q.delete();
                        fill_cnt   = 0;
                        drain_left = N;
                        out_cnt    = 0;
                        lat_cnt    = 1;
                    end
                end
            end
        end
    end

    // Downstream readiness: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus_if.out_ready = (rdy_phase % 3 == 0);
                2:       bus_if.out_ready = 1'($urandom_range(0, 1));
                default: bus_if.out_ready = 1'b1;
            endcase
            rdy_phase++;
        end
    end

    task automatic drive_sample(input logic [DW-1:0] d);
        bit acc;
        int t;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        acc = 0;
        t   = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus_if.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        bus_if.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL input_accept_timeout: got in_ready=0 for 200 cycles required 1");
        end
    endtask

    task automatic idle_cycles(input int n);
        bus_if.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int gap_after, input int gap_len);
        for (int i = 0; i < N; i++) begin
            drive_sample(base + DW'(i));
            if (i == gap_after) idle_cycles(gap_len);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((drain_left != 0 || fill_cnt != 0) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outputs pending required 0", drain_left);
        end
        idle_cycles(2);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(2);

        // Natural-order frame, no backpressure.
        rdy_mode = 0;
        send_frame(32'd0, -1, 0);
        wait_drain();

        // Same frame with a 1,0,0 ready pattern.
        rdy_mode = 1;
        send_frame(32'd0, -1, 0);
        wait_drain();

        // Input gap of three cycles after sample 5.
        rdy_mode = 0;
        send_frame(32'd0, 5, 3);
        wait_drain();

        // Two frames back to back.
        send_frame(32'd0, -1, 0);
        send_frame(32'd100, -1, 0);
        wait_drain();

        // Reset while output index 6 is presented, then a clean frame.
        send_frame(32'd200, -1, 0);
        begin
            int t = 0;
            while (out_cnt < 6 && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 200) begin
                checks++;
                errors++;
                $display("FAIL reset_point_timeout: got out_cnt=%0d required 6", out_cnt);
            end
        end
        rst_n = 1'b0;
        idle_cycles(1);
        rst_n = 1'b1;
        idle_cycles(2);
        send_frame(32'd300, -1, 0);
        wait_drain();

        // Randomised frames: random data, gaps and backpressure.
        for (int f = 0; f < 8; f++) begin
            rdy_mode = (f % 2 == 0) ? 2 : 1;
            for (int i = 0; i < N; i++) begin
                drive_sample($urandom);
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            end
            if ($urandom_range(0, 1) == 0) wait_drain();
        end
        wait_drain();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
